// File: rtl/uart_param.sv
// uart_param: parameterised UART transmitter and receiver sharing one free-running baud tick.
// TX serialises start/data/parity/stop; RX synchronises the line and samples at bit centres.
module uart_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW      = $clog2(OVERSAMPLE);

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_nx;
  logic [OW-1:0]        tx_os, tx_os_nx;
  logic [3:0]           tx_bit, tx_bit_nx;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nx;
  logic                 tx_par, tx_par_nx;
  logic                 tx_nx;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_os == OW'(OVERSAMPLE - 1));

  always_comb begin
    tx_state_nx = tx_state;
    tx_os_nx    = tx_os;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_par_nx   = tx_par;
    tx_nx       = tx;
    if (tx_state != TX_IDLE && tick)
      tx_os_nx = tx_bit_end ? '0 : tx_os + OW'(1);
    case (tx_state)
      TX_IDLE: begin
        tx_nx = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_state_nx = TX_START;
          tx_shift_nx = tx_data;
          tx_par_nx   = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
          tx_os_nx    = '0;
          tx_bit_nx   = '0;
          tx_nx       = 1'b0;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_nx = TX_DATA;
        tx_nx       = tx_shift[0];
        tx_shift_nx = tx_shift >> 1;
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit == 4'(DATA_BITS - 1)) begin
          tx_bit_nx = '0;
          if (PARITY != 0) begin
            tx_state_nx = TX_PARITY;
            tx_nx       = tx_par;
          end else begin
            tx_state_nx = TX_STOP;
            tx_nx       = 1'b1;
          end
        end else begin
          tx_bit_nx   = tx_bit + 4'd1;
          tx_nx       = tx_shift[0];
          tx_shift_nx = tx_shift >> 1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_nx = TX_STOP;
        tx_nx       = 1'b1;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit == 4'(STOP_BITS - 1)) begin
          tx_state_nx = TX_IDLE;
          tx_bit_nx   = '0;
        end else begin
          tx_bit_nx = tx_bit + 4'd1;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  // Ready is registered from the next state so it rises the clock the stop bit ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      tx_os    <= tx_os_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
      tx_par   <= tx_par_nx;
      tx       <= tx_nx;
      tx_ready <= (tx_state_nx == TX_IDLE);
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  rx_state_t            rx_state, rx_state_nx;
  logic [OW-1:0]        rx_os, rx_os_nx;
  logic [3:0]           rx_bit, rx_bit_nx;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nx;
  logic                 rx_par, rx_par_nx;
  logic                 rx_s1, rx_s2, rx_prev, rx_armed;
  logic                 rx_sample, rx_done;
  logic                 rx_par_exp, perr_calc, rx_hs;

  assign rx_sample = (rx_state == RX_START) ? (tick && rx_os == OW'(OVERSAMPLE / 2 - 1))
                                            : (tick && rx_os == OW'(OVERSAMPLE - 1));

  always_comb begin
    rx_state_nx = rx_state;
    rx_os_nx    = rx_os;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_par_nx   = rx_par;
    rx_done     = 1'b0;
    if (rx_state != RX_IDLE && tick)
      rx_os_nx = rx_sample ? '0 : rx_os + OW'(1);
    case (rx_state)
      RX_IDLE: if (rx_armed && rx_prev && !rx_s2) begin
        rx_state_nx = RX_START;
        rx_os_nx    = '0;
        rx_bit_nx   = '0;
      end
      RX_START: if (rx_sample) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA: if (rx_sample) begin
        rx_shift_nx = {rx_s2, rx_shift[DATA_BITS-1:1]};
        if (rx_bit == 4'(DATA_BITS - 1)) begin
          rx_bit_nx   = '0;
          rx_state_nx = (PARITY != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_nx = rx_bit + 4'd1;
        end
      end
      RX_PARITY: if (rx_sample) begin
        rx_par_nx   = rx_s2;
        rx_state_nx = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_done     = 1'b1;
        rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  // A low stop bit disarms start detection until the line is seen high again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_armed <= 1'b1;
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      if (rx_done && !rx_s2) rx_armed <= 1'b0;
      else if (rx_s2)        rx_armed <= 1'b1;
      rx_state <= rx_state_nx;
      rx_os    <= rx_os_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
      rx_par   <= rx_par_nx;
    end
  end

  assign rx_par_exp = (PARITY == 1) ? ~(^rx_shift) : ^rx_shift;
  assign perr_calc  = (PARITY != 0) && (rx_par != rx_par_exp);
  assign rx_hs      = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (rx_done && (!rx_valid || rx_hs)) begin
      rx_data       <= rx_shift;
      rx_valid      <= 1'b1;
      rx_parity_err <= perr_calc;
      rx_frame_err  <= !rx_s2;
      if (rx_hs) rx_overrun <= 1'b0;
    end else if (rx_done) begin
      rx_overrun <= 1'b1;
    end else if (rx_hs) begin
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance and an 8E1 instance, both at one bit = 16 clocks.
module tb_uart_param;
  localparam int BIT = 16;

  logic clk, rst;
  logic [7:0] tx_data_n, tx_data_e, rx_data_n, rx_data_e;
  logic tx_valid_n, tx_valid_e, tx_ready_n, tx_ready_e, tx_n, tx_e;
  logic rx_n, rx_e, line_n, line_e, loop_n, loop_e;
  logic rx_valid_n, rx_valid_e, rx_ready_n, rx_ready_e;
  logic perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e;
  int n_checks, n_fail, cyc;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         flip;
    bit         stop;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;
  vec_t vecs[8];

  assign rx_n = loop_n ? tx_n : line_n;
  assign rx_e = loop_e ? tx_e : line_e;

  uart_param #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .tx(tx_n), .rx(rx_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .rx_parity_err(perr_n), .rx_frame_err(ferr_n), .rx_overrun(ovr_n));

  uart_param #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .tx(tx_e), .rx(rx_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .rx_parity_err(perr_e), .rx_frame_err(ferr_e), .rx_overrun(ovr_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference frame, LSB = first bit on the line; parity here is always even.
  function automatic logic [15:0] frame_of(input logic [7:0] d, input bit par_on,
                                           input bit flip, input bit stop);
    logic p;
    p = (($countones(d) % 2) == 1) ^ flip;
    if (par_on) return {5'b0, stop, p, d, 1'b0};
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic int flen(input bit sel);
    return sel ? 11 : 10;
  endfunction

  // {valid, perr, ferr, ovr, data}
  function automatic logic [11:0] rx_stat(input bit sel);
    if (sel) return {rx_valid_e, perr_e, ferr_e, ovr_e, rx_data_e};
    return {rx_valid_n, perr_n, ferr_n, ovr_n, rx_data_n};
  endfunction

  function automatic logic tx_line(input bit sel);
    return sel ? tx_e : tx_n;
  endfunction

  function automatic logic tx_rdy(input bit sel);
    return sel ? tx_ready_e : tx_ready_n;
  endfunction

  task automatic set_line(input bit sel, input logic v);
    if (sel) line_e = v;
    else     line_n = v;
  endtask

  task automatic set_rx_ready(input bit sel, input logic v);
    if (sel) rx_ready_e = v;
    else     rx_ready_n = v;
  endtask

  task automatic set_tx(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin tx_data_e = d; tx_valid_e = v; end
    else     begin tx_data_n = d; tx_valid_n = v; end
  endtask

  task automatic drive_frame(input bit sel, input logic [7:0] d, input bit flip,
                             input bit stop, input bit keep_low);
    logic [15:0] f;
    f = frame_of(d, sel, flip, stop);
    for (int i = 0; i < flen(sel); i++) begin
      set_line(sel, f[i]);
      repeat (BIT) @(negedge clk);
    end
    if (!keep_low) set_line(sel, 1'b1);
  endtask

  task automatic wait_valid(input bit sel, input string name);
    int n;
    n = 0;
    while (!rx_stat(sel)[11] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, rx_stat(sel)[11], 1);
  endtask

  task automatic expect_rx(input bit sel, input string name, input logic [7:0] d,
                           input bit pe, input bit fe, input bit ovr);
    logic [11:0] s;
    s = rx_stat(sel);
    chk({name, "_data"}, s[7:0], d);
    chk({name, "_flags"}, s[10:8], {pe, fe, ovr});
  endtask

  task automatic handshake(input bit sel, input string name);
    @(negedge clk);
    set_rx_ready(sel, 1'b1);
    @(negedge clk);
    set_rx_ready(sel, 1'b0);
    chk({name, "_cleared"}, rx_stat(sel)[11:8], 4'b0000);
  endtask

  // Sends d from the TX side and checks the line waveform, tx_ready timing and loopback RX.
  task automatic tx_frame_check(input bit sel, input logic [7:0] d, input string name);
    logic [15:0] f;
    int len;
    f   = frame_of(d, sel, 1'b0, 1'b1);
    len = flen(sel) * BIT;
    @(negedge clk);
    chk({name, "_ready_before"}, tx_rdy(sel), 1);
    set_tx(sel, d, 1'b1);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == 1) set_tx(sel, d, 1'b0);
      if (k <= len && ((k - 1) % BIT == 0 || (k - 1) % BIT == BIT - 1))
        chk($sformatf("%s_tx_bit%0d", name, (k - 1) / BIT), tx_line(sel), f[(k - 1) / BIT]);
      if (k == len)     chk({name, "_ready_low_at_end"}, tx_rdy(sel), 0);
      if (k == len + 1) begin
        chk({name, "_ready_after_frame"}, tx_rdy(sel), 1);
        chk({name, "_tx_idle"}, tx_line(sel), 1);
      end
    end
    wait_valid(sel, name);
    expect_rx(sel, name, d, 1'b0, 1'b0, 1'b0);
    handshake(sel, name);
  endtask

  task automatic stream_test(input int n);
    int sent, prev, w, got, budget;
    logic [7:0] e;
    sent = 0; prev = 0; w = 0; got = 0; budget = 0;
    loop_n = 1'b1;
    rx_ready_n = 1'b1;
    fork
      begin
        tx_data_n  = 8'($urandom);
        tx_valid_n = 1'b1;
        while (sent < n && w < n * 400) begin
          @(negedge clk);
          w++;
          if (tx_ready_n) begin
            exp_q.push_back(tx_data_n);
            if (sent > 0) chk("b2b_spacing", cyc - prev, 10 * BIT + 1);
            prev = cyc;
            sent++;
            @(negedge clk);
            tx_data_n = 8'($urandom);
          end
        end
        tx_valid_n = 1'b0;
        chk("stream_sent", sent, n);
      end
      begin
        while (got < n && budget < n * 400) begin
          @(negedge clk);
          budget++;
          if (rx_valid_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stream_data", rx_data_n, e);
            chk("stream_flags", {perr_n, ferr_n, ovr_n}, 3'b000);
            got++;
          end
        end
        chk("stream_count", got, n);
      end
    join
    rx_ready_n = 1'b0;
    loop_n = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [7:0] rd;
    logic [15:0] f;
    bit sel, flip, stop, exp_pe;

    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    tx_data_n = '0; tx_data_e = '0; tx_valid_n = 1'b0; tx_valid_e = 1'b0;
    line_n = 1'b1; line_e = 1'b1; loop_n = 1'b0; loop_e = 1'b0;
    rx_ready_n = 1'b0; rx_ready_e = 1'b0;

    vecs[0] = '{0, 8'h48, 0, 1, 8'h48, 0, 0};
    vecs[1] = '{0, 8'h00, 0, 1, 8'h00, 0, 0};
    vecs[2] = '{0, 8'hFF, 0, 1, 8'hFF, 0, 0};
    vecs[3] = '{0, 8'h21, 0, 0, 8'h21, 0, 1};
    vecs[4] = '{1, 8'h6C, 0, 1, 8'h6C, 0, 0};
    vecs[5] = '{1, 8'h6C, 1, 1, 8'h6C, 1, 0};
    vecs[6] = '{1, 8'h01, 0, 1, 8'h01, 0, 0};
    vecs[7] = '{1, 8'h80, 1, 0, 8'h80, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_tx", {tx_n, tx_e}, 2'b11);
    chk("rst_tx_ready", {tx_ready_n, tx_ready_e}, 2'b00);
    chk("rst_rx_n", rx_stat(0), 12'h000);
    chk("rst_rx_e", rx_stat(1), 12'h000);
    rst = 1'b0;
    #1 chk("ready_before_first_clk", tx_ready_n, 0);
    @(negedge clk);
    chk("ready_first_clk", {tx_ready_n, tx_ready_e}, 2'b11);

    loop_n = 1'b1;
    tx_frame_check(0, 8'h48, "loop_48");
    loop_n = 1'b0;
    loop_e = 1'b1;
    tx_frame_check(1, 8'h6C, "loop_par_6c");
    loop_e = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive_frame(vecs[i].sel, vecs[i].d, vecs[i].flip, vecs[i].stop, 1'b0);
      wait_valid(vecs[i].sel, $sformatf("vec%0d", i));
      expect_rx(vecs[i].sel, $sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe,
                vecs[i].exp_fe, 1'b0);
      handshake(vecs[i].sel, $sformatf("vec%0d", i));
      repeat (BIT) @(negedge clk);
    end

    // Framing error with the line left low: no new frame until it returns high.
    drive_frame(0, 8'h21, 0, 0, 1'b1);
    wait_valid(0, "ferr");
    expect_rx(0, "ferr", 8'h21, 1'b0, 1'b1, 1'b0);
    handshake(0, "ferr");
    seen = 0;
    repeat (4 * BIT) begin
      @(negedge clk);
      seen |= rx_valid_n;
    end
    chk("ferr_no_rearm", seen, 0);
    line_n = 1'b1;
    repeat (BIT) @(negedge clk);
    drive_frame(0, 8'h33, 0, 1, 1'b0);
    wait_valid(0, "after_ferr");
    expect_rx(0, "after_ferr", 8'h33, 1'b0, 1'b0, 1'b0);
    handshake(0, "after_ferr");

    // Overrun: second frame arrives while the first is still held.
    drive_frame(0, 8'h65, 0, 1, 1'b0);
    drive_frame(0, 8'h6F, 0, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_valid", rx_valid_n, 1);
    expect_rx(0, "ovr", 8'h65, 1'b0, 1'b0, 1'b1);
    handshake(0, "ovr");

    // Short low glitch must be rejected and leave RX ready for a real frame.
    line_n = 1'b0;
    repeat (4) @(negedge clk);
    line_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= rx_valid_n;
    end
    chk("glitch_no_valid", seen, 0);
    drive_frame(0, 8'h5A, 0, 1, 1'b0);
    wait_valid(0, "after_glitch");
    expect_rx(0, "after_glitch", 8'h5A, 1'b0, 1'b0, 1'b0);
    handshake(0, "after_glitch");

    // Reset during data bit 3 of 0x57 in loopback.
    loop_n = 1'b1;
    @(negedge clk);
    set_tx(0, 8'h57, 1'b1);
    @(negedge clk);
    set_tx(0, 8'h57, 1'b0);
    repeat (4 * BIT + 7) @(negedge clk);
    chk("mid_tx_bit3", tx_n, 0);
    #2 rst = 1'b1;
    #1 chk("rst_async_tx", tx_n, 1);
    chk("rst_async_ready", tx_ready_n, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_release_ready_low", tx_ready_n, 0);
    @(negedge clk);
    chk("rst_release_ready_high", tx_ready_n, 1);
    seen = 0;
    repeat (12 * BIT) begin
      @(negedge clk);
      seen |= rx_valid_n;
    end
    chk("partial_discarded", seen, 0);
    tx_frame_check(0, 8'h57, "after_rst");
    loop_n = 1'b0;

    // Random direct-drive frames against the reference frame model.
    for (int i = 0; i < 12; i++) begin
      sel  = 1'($urandom_range(0, 1));
      rd   = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      f    = frame_of(rd, sel, flip, stop);
      exp_pe = sel && (f[9] != (($countones(rd) % 2) == 1));
      drive_frame(sel, rd, flip, stop, 1'b0);
      wait_valid(sel, $sformatf("rand%0d", i));
      expect_rx(sel, $sformatf("rand%0d", i), rd, exp_pe, !f[flen(sel) - 1], 1'b0);
      handshake(sel, $sformatf("rand%0d", i));
      repeat (BIT) @(negedge clk);
    end

    stream_test(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL provide parameter OVERSAMPLE, default 16, ticks per bit; the legal range is 8..32, even values only.
REQ-004 SHALL provide parameter DATA_BITS, default 8, payload width; the legal range is 5..9.
REQ-005 SHALL provide parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-006 SHALL provide parameter STOP_BITS, default 1; the legal values are 1 and 2.
REQ-007 SHALL provide port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL provide port tx_data, input, DATA_BITS bits: the byte to transmit.
REQ-010 SHALL provide port tx_valid, input, 1 bit: tx_data is offered.
REQ-011 SHALL provide port tx_ready, output, 1 bit: the transmitter can accept a byte.
REQ-012 SHALL provide port tx, output, 1 bit: serial line out, idle high.
REQ-013 SHALL provide port rx, input, 1 bit: serial line in, asynchronous to clk.
REQ-014 SHALL provide port rx_data, output, DATA_BITS bits: the received payload.
REQ-015 SHALL provide port rx_valid, output, 1 bit: rx_data and the error flags are valid.
REQ-016 SHALL provide port rx_ready, input, 1 bit: the consumer accepts the received byte.
REQ-017 SHALL provide port rx_parity_err, output, 1 bit: the parity of the held frame mismatched.
REQ-018 SHALL provide port rx_frame_err, output, 1 bit: the first stop bit of the held frame sampled low.
REQ-019 SHALL provide port rx_overrun, output, 1 bit: one or more frames were dropped while rx_valid was high.

Function
REQ-020 SHALL generate a one-cycle tick every DIV = max(1, floor(CLK_HZ/(BAUD*OVERSAMPLE))) clocks, from a free-running counter shared by TX and RX.
REQ-021 SHALL make each serial bit exactly OVERSAMPLE ticks long; frame order is start(0), data LSB first, optional parity, STOP_BITS stop bits(1).
REQ-022 SHALL compute parity as the XOR of the data bits, inverted for odd mode.
REQ-023 TX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, with these transitions:
- IDLE -> START on tx_valid&&tx_ready.
- START -> DATA after OVERSAMPLE ticks.
- DATA -> PARITY, or -> STOP when PARITY=0, after DATA_BITS bits.
- STOP -> IDLE after STOP_BITS bits.
REQ-024 SHALL register tx_ready high only in IDLE; on a handshake, SHALL capture tx_data and drop tx_ready on the next clock.
REQ-025 SHALL assert tx_ready on the clock after the last stop bit ends, so back-to-back frames carry no extra idle bit.
REQ-026 SHALL register tx and hold it high in IDLE.
REQ-027 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-028 RX FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, with these transitions:
- IDLE -> START on a synchronized falling edge.
- In START, sample at OVERSAMPLE/2 ticks; low -> DATA, high -> IDLE (glitch rejected, no output).
REQ-029 SHALL sample each subsequent bit OVERSAMPLE ticks after the previous sample, i.e. at bit centre.
REQ-030 SHALL sample only the first stop bit and return to IDLE immediately after that sample, so that the next start edge is detected.
REQ-031 On frame completion with rx_valid low, SHALL load rx_data, rx_parity_err and rx_frame_err and set rx_valid on the next clock.
REQ-032 SHALL hold rx_data, rx_valid and the error flags stable until rx_valid&&rx_ready.
REQ-033 On rx_valid&&rx_ready, SHALL clear rx_valid, the error flags and rx_overrun on the next clock.
REQ-034 On frame completion with rx_valid high and no handshake in the same cycle, SHALL discard the new frame, keep the old data and set rx_overrun (sticky).
REQ-035 When a handshake and a frame completion occur in the same cycle, SHALL load the new frame (rx_valid stays high) and leave rx_overrun clear.
REQ-036 When rx_frame_err is detected, SHALL still present the data.
REQ-037 While rx_frame_err is set, SHALL not re-arm the RX FSM until rx has been sampled high.

Reset
REQ-038 While rst is high, SHALL force tx=1, tx_ready=0, rx_valid=0, rx_data=0, all error flags 0, both FSMs to IDLE, and the tick and bit counters to 0.
REQ-039 A mid-frame reset SHALL abort the frame with tx returning to 1 asynchronously, and the received partial frame SHALL be discarded.
REQ-040 SHALL raise tx_ready on the first clock after rst deasserts.

Verification
Bench parameters for all scenarios: CLK_HZ=1843200, BAUD=115200, OVERSAMPLE=16, so DIV=1 and one bit = 16 clocks.
REQ-041 Bench SHALL cover loopback: 8N1, tx wired to rx, send 0x48 -> tx low for 16 clocks, then bits 0,0,0,1,0,0,1,0 at 16 clocks each, then high; rx_valid=1 with rx_data=0x48 and no errors; tx_ready high 160 clocks after the handshake.
REQ-042 Bench SHALL cover even parity (PARITY=2): send 0x6C -> parity bit 0; inject parity 1 on rx -> rx_data=0x6C, rx_parity_err=1.
REQ-043 Bench SHALL cover a framing error: drive the stop bit low for 0x21 -> rx_data=0x21, rx_frame_err=1; no new frame until the line has been high.
REQ-044 Bench SHALL cover overrun: hold rx_ready=0, receive 0x65 then 0x6F -> rx_data=0x65, rx_overrun=1; after a handshake all flags are 0.
REQ-045 Bench SHALL cover glitch rejection: an rx low pulse of 4 clocks -> no rx_valid, and the FSM is back in IDLE within 10 clocks.
REQ-046 Bench SHALL cover reset mid-frame: assert rst during data bit 3 of 0x57 -> tx=1 immediately, tx_ready=1 one clock after release, and a following send of 0x57 is received correctly.
